// File: rtl/jtag_core_tap.sv
// jtag_core_tap: IEEE 1149.1 TAP controller front-ending a small arithmetic core.
//   The 2-bit IR selects one of four data registers: OPERAND, IDCODE, RESULT or BYPASS.
//   UPD_DR with OPERAND selected drives registered operands to the core.
// Configuration macro: JTAG_CORE_IDCODE_EN
//   defined   -> IDCODE DR is built, opcode 01 selects it, reset instruction is IDCODE
//   undefined -> no IDCODE DR, opcode 01 behaves as BYPASS, reset instruction is BYPASS
// Ports:
//   tck     in   TAP clock; all state changes on its rising edge
//   rst     in   synchronous active-high reset
//   tms     in   test mode select
//   tdi     in   test data in
//   tdo     out  test data out, combinational: LSB of the active shift register
//   tdo_en  out  high while in SHIFT_DR or SHIFT_IR
//   result  in   4-bit result word from the arithmetic core
//   a, b    out  2-bit registered operands
//   op_code out  registered operation select (1 = add, 0 = multiply)
module jtag_core_tap #(
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
    input  logic       tck,
    input  logic       rst,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    input  logic [3:0] result,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic       op_code
);

    localparam int unsigned IR_W  = 2;
    localparam int unsigned OP_W  = 5;
    localparam int unsigned RES_W = 4;

    localparam logic [IR_W-1:0] OPC_OPERAND = 2'b00;
    localparam logic [IR_W-1:0] OPC_IDCODE  = 2'b01;
    localparam logic [IR_W-1:0] OPC_RESULT  = 2'b10;
    localparam logic [IR_W-1:0] OPC_BYPASS  = 2'b11;

`ifdef JTAG_CORE_IDCODE_EN
    localparam int unsigned     ID_W     = 32;
    localparam logic [IR_W-1:0] IR_RESET = OPC_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RESET = OPC_BYPASS;
`endif

    // An IDCODE with bit 0 clear would be indistinguishable from a BYPASS capture.
    if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
        $error("IDCODE_VAL bit 0 must be 1");
    end

    typedef enum logic [3:0] {
        TLR      = 4'h0,
        RTI      = 4'h1,
        SEL_DR   = 4'h2,
        CAP_DR   = 4'h3,
        SHIFT_DR = 4'h4,
        EXIT1_DR = 4'h5,
        PAUSE_DR = 4'h6,
        EXIT2_DR = 4'h7,
        UPD_DR   = 4'h8,
        SEL_IR   = 4'h9,
        CAP_IR   = 4'hA,
        SHIFT_IR = 4'hB,
        EXIT1_IR = 4'hC,
        PAUSE_IR = 4'hD,
        EXIT2_IR = 4'hE,
        UPD_IR   = 4'hF
    } tap_state_t;

    tap_state_t state;
    tap_state_t next_state;

    logic [IR_W-1:0]  ir;
    logic [IR_W-1:0]  ir_sr;
    logic [OP_W-1:0]  op_sr;
    logic [RES_W-1:0] res_sr;
    logic             byp_sr;
`ifdef JTAG_CORE_IDCODE_EN
    logic [ID_W-1:0]  id_sr;
`endif

    // TAP state register
    always_ff @(posedge tck) begin
        if (rst) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // TAP next-state decode
    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = tms ? TLR      : RTI;
            RTI:      next_state = tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: next_state = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: next_state = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: next_state = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   next_state = tms ? SEL_DR   : RTI;
            SEL_IR:   next_state = tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: next_state = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: next_state = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: next_state = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   next_state = tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    // IR, data registers and operand outputs; states not listed (incl. PAUSE) hold everything
    always_ff @(posedge tck) begin
        if (rst) begin
            ir      <= IR_RESET;
            ir_sr   <= '0;
            op_sr   <= '0;
            res_sr  <= '0;
            byp_sr  <= 1'b0;
`ifdef JTAG_CORE_IDCODE_EN
            id_sr   <= '0;
`endif
            a       <= '0;
            b       <= '0;
            op_code <= 1'b0;
            tdo_en  <= 1'b0;
        end else begin
            case (state)
                TLR:      ir    <= IR_RESET;
                CAP_IR:   ir_sr <= 2'b01;
                SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]};
                UPD_IR:   ir    <= ir_sr;
                CAP_DR: begin
                    case (ir)
                        OPC_OPERAND: op_sr  <= {op_code, b, a};
`ifdef JTAG_CORE_IDCODE_EN
                        OPC_IDCODE:  id_sr  <= IDCODE_VAL;
`endif
                        OPC_RESULT:  res_sr <= result;
                        default:     byp_sr <= 1'b0;
                    endcase
                end
                SHIFT_DR: begin
                    case (ir)
                        OPC_OPERAND: op_sr  <= {tdi, op_sr[OP_W-1:1]};
`ifdef JTAG_CORE_IDCODE_EN
                        OPC_IDCODE:  id_sr  <= {tdi, id_sr[ID_W-1:1]};
`endif
                        OPC_RESULT:  res_sr <= {tdi, res_sr[RES_W-1:1]};
                        default:     byp_sr <= tdi;
                    endcase
                end
                UPD_DR: begin
                    if (ir == OPC_OPERAND) begin
                        a       <= op_sr[1:0];
                        b       <= op_sr[3:2];
                        op_code <= op_sr[4];
                    end
                end
                default: ;
            endcase
            // Registered from next_state so tdo_en tracks the current shift state exactly
            tdo_en <= (next_state == SHIFT_DR) || (next_state == SHIFT_IR);
        end
    end

    // tdo mux: LSB of whichever shift register is active, 0 outside shift states
    always_comb begin
        tdo = 1'b0;
        if (state == SHIFT_IR) begin
            tdo = ir_sr[0];
        end else if (state == SHIFT_DR) begin
            case (ir)
                OPC_OPERAND: tdo = op_sr[0];
`ifdef JTAG_CORE_IDCODE_EN
                OPC_IDCODE:  tdo = id_sr[0];
`endif
                OPC_RESULT:  tdo = res_sr[0];
                default:     tdo = byp_sr;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_core_tap.sv
// Directed self-checking bench for jtag_core_tap.
module tb_jtag_core_tap;

    localparam logic [3:0] ST_TLR      = 4'h0;
    localparam logic [3:0] ST_SHIFT_DR = 4'h4;

    logic       tck;
    logic       rst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] result;
    logic [1:0] a;
    logic [1:0] b;
    logic       op_code;

    int n_cmp = 0;
    int n_bad = 0;

    jtag_core_tap #(.IDCODE_VAL(32'h1234_5679)) dut (
        .tck     (tck),
        .rst     (rst),
        .tms     (tms),
        .tdi     (tdi),
        .tdo     (tdo),
        .tdo_en  (tdo_en),
        .result  (result),
        .a       (a),
        .b       (b),
        .op_code (op_code)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive tms/tdi, take one rising edge, settle 1ns past it
    task automatic tick(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp);
        logic [3:0] st;
        st = dut.state;
        check(tag, 32'(st), 32'(exp));
    endtask

    // From RTI: load IR with v, back to RTI; cap returns tdo seen during the IR shift
    task automatic scan_ir(input logic [1:0] v, output logic [1:0] cap);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cap[0] = tdo;
        tick(1'b0, v[0]);
        cap[1] = tdo;
        tick(1'b1, v[1]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // From RTI: n-bit DR scan LSB first, back to RTI; dout collects tdo per shift
    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0]  cap;
        logic [31:0] dout;
        logic [31:0] din;

        rst    = 1'b1;
        tms    = 1'b0;
        tdi    = 1'b0;
        result = 4'b0000;

        // Reset for one edge
        tick(1'b0, 1'b0);
        rst = 1'b0;
        check_state("reset_state", ST_TLR);
        check("reset_a", 32'(a), 32'd0);
        check("reset_b", 32'(b), 32'd0);
        check("reset_op", 32'(op_code), 32'd0);
        check("reset_tdo_en", 32'(tdo_en), 32'd0);
        check("reset_tdo", 32'(tdo), 32'd0);

        // Walk to SHIFT_DR, then five tms=1 edges back to TLR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_state("reach_shift_dr", ST_SHIFT_DR);
        check("shift_dr_tdo_en", 32'(tdo_en), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check_state("tms5_tlr", ST_TLR);
        check("tms5_tdo_en", 32'(tdo_en), 32'd0);

        // Reset instruction: 32-bit DR scan reads IDCODE or acts as bypass
        tick(1'b0, 1'b0);
        din = 32'hA5A5_0F0F;
        scan_dr(32, din, dout);
`ifdef JTAG_CORE_IDCODE_EN
        check("idcode_scan", dout, 32'h1234_5679);
`else
        check("reset_bypass_scan", dout, {din[30:0], 1'b0});
`endif

        // Operand load: 1,1,0,1,1 -> a=3 b=2 op=1
        scan_ir(2'b00, cap);
        check("ir_capture", 32'(cap), 32'h1);
        scan_dr(5, 32'h1B, dout);
        check("operand_capture_old", dout, 32'h0);
        check("operand_a", 32'(a), 32'd3);
        check("operand_b", 32'(b), 32'd2);
        check("operand_op", 32'(op_code), 32'd1);

        // Operand readback with the same value shifted back in
        scan_dr(5, 32'h1B, dout);
        check("operand_readback", dout, 32'h1B);
        check("operand_a_keep", 32'(a), 32'd3);

        // Result readback 1100 -> tdo 0,0,1,1; operands untouched by a non-OPERAND update
        result = 4'b1100;
        scan_ir(2'b10, cap);
        scan_dr(4, 32'h0, dout);
        check("result_readback", dout, 32'hC);
        check("result_keeps_a", 32'(a), 32'd3);
        check("result_keeps_b", 32'(b), 32'd2);
        check("result_keeps_op", 32'(op_code), 32'd1);

        // Bypass: tdi 1,0,1 -> tdo 0,1,0
        scan_ir(2'b11, cap);
        scan_dr(3, 32'h5, dout);
        check("bypass_101", dout, 32'h2);

        // Opcode 01: IDCODE low bits or bypass
        scan_ir(2'b01, cap);
        scan_dr(3, 32'h7, dout);
`ifdef JTAG_CORE_IDCODE_EN
        check("opcode01_idcode", dout, 32'h1);
`else
        check("opcode01_bypass", dout, 32'h6);
`endif

        // Operand load 00101 with a PAUSE_DR detour after two bits -> a=1 b=1 op=0
        scan_ir(2'b00, cap);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("pause_tdo_en", 32'(tdo_en), 32'd0);
        check("pause_tdo", 32'(tdo), 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("pause_a", 32'(a), 32'd1);
        check("pause_b", 32'(b), 32'd1);
        check("pause_op", 32'(op_code), 32'd0);

        // Reset after three operand shifts: outputs clear, no update afterwards
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
        check_state("midscan_rst_state", ST_TLR);
        check("midscan_rst_a", 32'(a), 32'd0);
        check("midscan_rst_b", 32'(b), 32'd0);
        check("midscan_rst_op", 32'(op_code), 32'd0);
        check("midscan_rst_tdo_en", 32'(tdo_en), 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("post_rst_a", 32'(a), 32'd0);
        check("post_rst_op", 32'(op_code), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_core_tap.md
JTAG_CORE_TAP -- requirements
Module: jtag_core_tap

Interface
REQ-001 Parameter IDCODE_VAL, default 32'h1234_5679, sets the 32-bit device identification word; bit 0 SHALL be 1.
REQ-002 tck  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 tms  input  1  test mode select, sampled on the rising edge of tck.
REQ-005 tdi  input  1  test data in, sampled on the rising edge of tck.
REQ-006 tdo  output  1  test data out; LSB of the active shift register.
REQ-007 tdo_en  output  1  high only in SHIFT_DR or SHIFT_IR.
REQ-008 result  input  4  result word from the downstream arithmetic core.
REQ-009 a  output  2  registered operand A to the arithmetic core.
REQ-010 b  output  2  registered operand B to the arithmetic core.
REQ-011 op_code  output  1  registered operation select: 1 = add, 0 = multiply.

Function
REQ-012 The TAP FSM SHALL implement the 16 IEEE 1149.1 states with the following transitions, listed as state: next state on tms=0 / next state on tms=1.
- TLR: RTI / TLR
- RTI: RTI / SEL_DR
- SEL_DR: CAP_DR / SEL_IR
- SEL_IR: CAP_IR / TLR
- CAP_x: SHIFT_x / EXIT1_x
- SHIFT_x: SHIFT_x / EXIT1_x
- EXIT1_x: PAUSE_x / UPD_x
- PAUSE_x: PAUSE_x / EXIT2_x
- EXIT2_x: SHIFT_x / UPD_x
- UPD_x: RTI / SEL_DR
REQ-013 From any state, tms=1 for 5 consecutive edges SHALL reach TLR.
REQ-014 The instruction register (IR) SHALL be 2 bits wide, with these opcodes:
- 00 OPERAND (5-bit DR)
- 01 IDCODE (32-bit DR)
- 10 RESULT (4-bit DR)
- 11 BYPASS (1-bit DR)
REQ-015 On the edge in CAP_IR, the IR shift register SHALL load 2'b01.
REQ-016 On each edge in SHIFT_IR, the IR shift register SHALL shift: sr <= {tdi, sr[1]}.
REQ-017 On the edge in UPD_IR, the IR SHALL load the IR shift register.
REQ-018 On the edge in CAP_DR, the selected DR SHALL load its capture value:
- OPERAND: {op_code, b, a}
- IDCODE: IDCODE_VAL
- RESULT: the result input
- BYPASS: 0
REQ-019 On each edge in SHIFT_DR, the selected DR SHALL shift LSB-first: sr <= {tdi, sr[N-1:1]}.
REQ-020 tdo SHALL be combinational: sr[0] of the selected shift register while tdo_en=1, otherwise 0.
REQ-021 On the edge in UPD_DR with IR=OPERAND, a, b and op_code SHALL load OPERAND sr[1:0], sr[3:2] and sr[4] respectively, visible the following cycle; UPD_DR with any other instruction SHALL leave them unchanged.
REQ-022 Outputs a, b and op_code SHALL hold their values in every state except UPD_DR with OPERAND selected, including TLR entered via tms.
REQ-023 In TLR, the IR SHALL be forced to the reset instruction on every edge.
REQ-024 PAUSE states SHALL hold all shift-register contents unchanged.

Reset
REQ-025 On an edge with rst=1, regardless of state:
- FSM SHALL go to TLR.
- IR SHALL load the reset instruction.
- All shift registers SHALL clear to 0.
- a, b and op_code SHALL clear to 0.
- tdo and tdo_en SHALL be 0 from the next cycle.
REQ-026 Reset mid-SHIFT_DR SHALL discard the partial scan; no operand update occurs.

Configuration
REQ-027 Macro JTAG_CORE_IDCODE_EN controls IDCODE support.
- Defined: opcode 01 selects the IDCODE DR, and the reset instruction is IDCODE.
- Undefined: no IDCODE register is built, opcode 01 behaves as BYPASS, and the reset instruction is BYPASS.

Verification
REQ-028 Reset and idle checks:
- rst=1 for 1 edge -> state TLR, a=0, b=0, op_code=0, tdo_en=0.
- Then tms=1 for 5 edges from SHIFT_DR -> state TLR.
REQ-029 Operand load: IR scan 00, then DR scan shifting tdi 1,1,0,1,1 (LSB first = 5'b11011) -> after UPD_DR: a=3, b=2, op_code=1.
REQ-030 Result readback: result=4'b1100 held, IR scan 10, CAP_DR, then 4 SHIFT_DR edges -> tdo sequence 0,0,1,1.
REQ-031 IDCODE readback: with JTAG_CORE_IDCODE_EN and IDCODE_VAL=32'h1234_5679, reset, then a 32-bit DR scan -> tdo yields 0x12345679 LSB-first; without the macro, the same scan -> 1-bit bypass behaviour.
REQ-032 Bypass: IR=11, shift tdi 1,0,1 -> tdo 0,1,0 (one-cycle delay).
REQ-033 Reset mid-operand scan: rst=1 mid-operand scan after 3 shifts with a=1 previously loaded -> a=b=op_code=0, state TLR, no update.
